// File: rtl/gfx_rom_pkg.sv
// Shared types and default widths for the graphics-ROM arbiter.
// State encoding for the arbiter FSM plus ROM word/address widths.
package gfx_rom_pkg;
  localparam int ROM_AW = 21;
  localparam int ROM_DW = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;
endpackage

// File: rtl/gfx_rom_rr_pick.sv
// Round-robin picker: first pending port at or above rr_ptr, wrapping modulo NUM_PORTS.
// Purely combinational; no latency, no flow control of its own.
module gfx_rom_rr_pick #(
  parameter int NUM_PORTS = 3,
  parameter int PW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [PW-1:0]        rr_ptr,
  output logic [PW-1:0]        grant,
  output logic                 grant_valid
);

  logic [PW:0] idx;

  // Scan from the farthest offset down so the nearest pending port wins last.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NUM_PORTS)) idx = idx - (PW+1)'(NUM_PORTS);
      if (pending[idx[PW-1:0]]) begin
        grant       = idx[PW-1:0];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gfx_rom_arbiter.sv
// Round-robin share of one ROM SDRAM channel with a last-word cache per port.
// Hit: 1 cycle; miss: 1 + downstream + 1 cycles; ports back-pressured by withholding the ack toggle.
module gfx_rom_arbiter
  import gfx_rom_pkg::*;
#(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_WIDTH = ROM_AW,
  parameter int DATA_WIDTH = ROM_DW
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS-1:0]            port_req,
  output logic [NUM_PORTS-1:0]            port_ack,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] port_data,
  output logic [ADDR_WIDTH-1:0]           sdr_addr,
  output logic                            sdr_req,
  input  logic                            sdr_ack,
  input  logic [DATA_WIDTH-1:0]           sdr_data,
  input  logic                            flush,
  output logic                            busy
);

  localparam int PW = $clog2(NUM_PORTS);

  state_t                  state;
  state_t                  state_nxt;
  logic [NUM_PORTS-1:0]    pending;
  logic [NUM_PORTS-1:0]    valid;
  logic [ADDR_WIDTH-1:0]   paddr     [NUM_PORTS];
  logic [ADDR_WIDTH-1:0]   last_addr [NUM_PORTS];
  logic [DATA_WIDTH-1:0]   pdata     [NUM_PORTS];
  logic [DATA_WIDTH-1:0]   last_data [NUM_PORTS];
  logic [PW-1:0]           rr_ptr;
  logic [PW-1:0]           grant;
  logic [PW-1:0]           gnt_q;
  logic                    grant_valid;
  logic                    hit;
  logic                    fill;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign paddr[i] = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign port_data[i*DATA_WIDTH +: DATA_WIDTH] = pdata[i];
  end

  assign pending = port_req ^ port_ack;

  gfx_rom_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PW        (PW)
  ) u_pick (
    .pending     (pending),
    .rr_ptr      (rr_ptr),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign hit  = grant_valid && valid[grant] && (paddr[grant] == last_addr[grant]);
  assign fill = (state == ST_WAIT) && (sdr_ack == sdr_req);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_valid && !hit) state_nxt = ST_WAIT;
      ST_WAIT: if (sdr_ack == sdr_req) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_WAIT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      port_ack <= '0;
      sdr_req  <= 1'b0;
      sdr_addr <= '0;
      rr_ptr   <= '0;
      gnt_q    <= '0;
      valid    <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        pdata[i]     <= '0;
        last_addr[i] <= '0;
        last_data[i] <= '0;
      end
    end else begin
      if (state == ST_IDLE && grant_valid) begin
        if (grant == PW'(NUM_PORTS - 1)) rr_ptr <= '0;
        else                             rr_ptr <= grant + 1'b1;
        if (hit) begin
          pdata[grant]    <= last_data[grant];
          port_ack[grant] <= ~port_ack[grant];
        end else begin
          sdr_addr <= paddr[grant];
          sdr_req  <= ~sdr_req;
          gnt_q    <= grant;
        end
      end
      if (fill) begin
        pdata[gnt_q]     <= sdr_data;
        port_ack[gnt_q]  <= ~port_ack[gnt_q];
        last_addr[gnt_q] <= sdr_addr;
        last_data[gnt_q] <= sdr_data;
        valid[gnt_q]     <= 1'b1;
      end
      // Later assignment wins: a flush coinciding with a fill leaves the entry invalid.
      if (flush) valid <= '0;
    end
  end

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// Scoreboard bench for gfx_rom_arbiter with a fixed-latency SDRAM responder.
module tb_gfx_rom_arbiter;
  localparam int NP  = 3;
  localparam int AW  = 21;
  localparam int DW  = 32;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            resetn = 1'b1;
  logic [NP*AW-1:0] port_addr = '0;
  logic [NP-1:0]   port_req = '0;
  logic [NP-1:0]   port_ack;
  logic [NP*DW-1:0] port_data;
  logic [AW-1:0]   sdr_addr;
  logic            sdr_req;
  logic            sdr_ack;
  logic [DW-1:0]   sdr_data;
  logic            flush;
  logic            busy;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   acc = 0;
  int   lat_cnt;
  bit   flush_on_fill = 0;

  always #5 clk = ~clk;

  gfx_rom_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .port_addr (port_addr),
    .port_req  (port_req),
    .port_ack  (port_ack),
    .port_data (port_data),
    .sdr_addr  (sdr_addr),
    .sdr_req   (sdr_req),
    .sdr_ack   (sdr_ack),
    .sdr_data  (sdr_data),
    .flush     (flush),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    if (a == 21'h00100) return 32'hDEADBEEF;
    return {a[10:0], a} ^ 32'h3C5A_0000;
  endfunction

  // SDRAM responder: acks LAT edges after the request toggle, optionally with a flush pulse.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sdr_ack  <= 1'b0;
      sdr_data <= '0;
      flush    <= 1'b0;
      lat_cnt  <= 0;
    end else begin
      flush <= 1'b0;
      if (sdr_req != sdr_ack) begin
        if (lat_cnt == LAT - 1) begin
          sdr_ack  <= sdr_req;
          sdr_data <= rom_word(sdr_addr);
          lat_cnt  <= 0;
          if (flush_on_fill) flush <= 1'b1;
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end
    end
  end

  logic [NP-1:0] ack_prev = '0;
  logic          sreq_prev = 1'b0;
  logic [DW-1:0] data_prev [NP];

  // Output monitor: every ack toggle pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (!resetn) begin
      ack_prev  = '0;
      sreq_prev = 1'b0;
      for (int p = 0; p < NP; p++) data_prev[p] = '0;
    end else begin
      if (sdr_req !== sreq_prev) acc++;
      sreq_prev = sdr_req;
      for (int p = 0; p < NP; p++) begin
        if (port_ack[p] !== ack_prev[p]) begin
          if (sb_q.size() == 0) begin
            check("unexpected_ack", sb_q.size(), 1);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("ack_port", p, e.port);
            check("ack_data", port_data[p*DW +: DW], e.data);
          end
        end else if (port_data[p*DW +: DW] !== data_prev[p]) begin
          check("data_held", port_data[p*DW +: DW], data_prev[p]);
        end
        data_prev[p] = port_data[p*DW +: DW];
      end
      ack_prev = port_ack;
    end
  end

  task automatic req(input int p, input logic [AW-1:0] a);
    exp_t e;
    e.port = p;
    e.data = rom_word(a);
    port_addr[p*AW +: AW] = a;
    port_req[p] = ~port_req[p];
    sb_q.push_back(e);
  endtask

  task automatic wait_ack(input int p, output int cyc, output int bcyc);
    cyc  = 0;
    bcyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) bcyc++;
      if (port_ack[p] == port_req[p]) break;
    end
    check("ack_seen", port_ack[p], port_req[p]);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, bcyc, a0, issued, done;
    logic [NP-1:0] seen;

    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", port_ack, 0);
    check("rst_data", |port_data, 0);
    check("rst_sdr_req", sdr_req, 0);
    check("rst_sdr_addr", sdr_addr, 0);
    check("rst_busy", busy, 0);
    resetn = 1'b1;

    // Single miss on port0
    req(0, 21'h00100);
    @(posedge clk);
    #1;
    check("miss_sdr_req", sdr_req, 1);
    check("miss_sdr_addr", sdr_addr, 21'h00100);
    check("miss_busy", busy, 1);
    wait_ack(0, cyc, bcyc);
    check("miss_lat_rest", cyc, LAT + 1);
    check("miss_busy_cycles", bcyc, LAT);

    // Repeat hit
    @(negedge clk); #1;
    a0 = acc;
    req(0, 21'h00100);
    wait_ack(0, cyc, bcyc);
    check("hit_lat", cyc, 1);
    check("hit_busy", bcyc, 0);
    @(negedge clk); #1;
    check("hit_no_sdr", acc, a0);

    // Per-port isolation
    a0 = acc;
    req(1, 21'h00100);
    wait_ack(1, cyc, bcyc);
    check("iso_lat", cyc, LAT + 2);
    @(negedge clk); #1;
    check("iso_sdr", acc, a0 + 1);

    // Flush coinciding with a fill
    flush_on_fill = 1;
    req(2, 21'h1FFFFF);
    wait_ack(2, cyc, bcyc);
    check("flush_fill_lat", cyc, LAT + 2);
    flush_on_fill = 0;
    @(negedge clk); #1;
    a0 = acc;
    req(2, 21'h1FFFFF);
    wait_ack(2, cyc, bcyc);
    check("post_flush_lat", cyc, LAT + 2);
    @(negedge clk); #1;
    check("post_flush_sdr", acc, a0 + 1);

    // Round-robin with all ports continuously pending
    a0 = acc;
    req(0, 21'h01000);
    req(1, 21'h01001);
    req(2, 21'h01002);
    issued = 3;
    done = 0;
    seen = port_ack;
    for (int c = 0; c < 300 && done < 6; c++) begin
      @(negedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (port_ack[p] != seen[p]) begin
          seen[p] = port_ack[p];
          done++;
          if (issued < 6) begin
            req(p, 21'h01000 + AW'(issued));
            issued++;
          end
        end
      end
    end
    check("rr_done", done, 6);
    check("rr_sdr", acc, a0 + 6);

    // Async reset in the middle of a WAIT
    @(posedge clk); #1;
    req(0, 21'h02000);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midwait_busy", busy, 1);
    resetn = 1'b0;
    port_req = '0;
    #1;
    check("arst_ack", port_ack, 0);
    check("arst_sdr_req", sdr_req, 0);
    check("arst_busy", busy, 0);
    sb_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    req(1, 21'h00100);
    wait_ack(1, cyc, bcyc);
    check("after_rst_lat", cyc, LAT + 2);

    @(negedge clk); #1;
    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
